ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
- Upstream stage of the memory-mapped keyboard register: receives PS/2 set-2 scan codes from a physical keyboard and drives the 16-bit `kb_in` word of the data memory.
- Follows Hack semantics: output holds the Hack key code of the currently held key, and 0 when no mapped key is held.
- Contains a PS/2 line synchroniser/filter, frame receiver FSM, prefix decoder and scan-code-to-Hack translation.

Parameters:
- FILTER_LEN, 4, consecutive equal samples of ps2_clk required before accepting a level change.
- TIMEOUT_CYCLES, 50000, clk cycles without a falling ps2_clk edge mid-frame before the frame is aborted.

Ports:
- clk  in  1  system clock; all state in this domain.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ps2_clk  in  1  raw PS/2 clock, asynchronous, idle high.
- ps2_data  in  1  raw PS/2 data, asynchronous, idle high.
- kb_out  out  16  Hack key code of the held key, 0 if none; connects to `kb_in` of data memory.
- code_valid  out  1  one-cycle pulse when a complete, good frame is received.
- frame_err  out  1  one-cycle pulse on parity error, bad start/stop bit, or timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - kb_out=0, code_valid=0, frame_err=0.
  - Frame FSM=IDLE, prefix flags cleared.
  - Synchronisers and filter preset to 1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - ps2_clk additionally passes through a FILTER_LEN sample filter.
  - Falling edge = filtered level 1->0. ps2_data is sampled on that cycle.
- Frame FSM, one transition per falling edge:
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay in IDLE (no error).
  - DATA: shift 8 bits in, LSB first. After the 8th bit go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: frame is good if stop=1 and the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
    - Good frame: code_valid pulses on the cycle after the stop edge, byte goes to the decoder.
    - Bad frame: frame_err pulses, byte is discarded.
    - Either way, return to IDLE.
  - Timeout: in any state except IDLE, a timer counts clk cycles and resets on each falling edge. When it reaches TIMEOUT_CYCLES: frame_err pulses, FSM goes to IDLE, partial byte is discarded, prefix flags are kept.
- Decoder (processes each good byte in the cycle after code_valid):
  - 0xE0: set the ext flag, no output change.
  - 0xF0: set the brk flag, no output change.
  - Any other byte: translate {ext, byte} to a Hack code, then clear both flags.
    - Make (brk=0) with a nonzero translation: kb_out = code. This applies even if another key is held (last make wins). A typematic repeat of the same key therefore leaves kb_out unchanged.
    - Break (brk=1): if the translation equals the current kb_out, set kb_out=0. Otherwise no change.
    - Unmapped code (translation 0): ignored, flags still cleared.
- Latency: kb_out updates 2 clk cycles after the falling ps2_clk edge of the stop bit (one cycle to code_valid, one cycle in the decoder).
- Translation map (Hack codes):
  - Letters: A-Z map to 65-90; unshifted keys produce upper case, shift is ignored.
  - Digits: 0-9 map to 48-57.
  - Space = 32.
  - Enter = 128, Backspace = 129.
  - Arrows: Left = 130, Up = 131, Right = 132, Down = 133.
  - Home = 134, End = 135, PgUp = 136, PgDn = 137, Insert = 138, Delete = 139.
  - Esc = 140.
  - F1-F12 = 141-152.
  - All other codes map to 0.
- Extended codes only match when ext=1. Example: E0 6B = Left, while plain 6B (keypad 4) = 0.

Decomposition:
- Shared package `hack_pkg`:
  - Hack key-code constants (KEY_NEWLINE=128 ... KEY_F12=152).
  - PS/2 prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Frame FSM state enum.
- Sub-module `ps2_scan_xlate`: purely combinational map from {ext(1), scan(8)} to hack_code(16). Keeps the lookup table out of the sequential logic.

Test Plan:
- Frame 0x1C with correct parity, then F0 1C -> code_valid pulses 3 times; kb_out goes 0 -> 65 two cycles after the first stop edge, then returns to 0 after the 1C of the break.
- E0 75 then E0 F0 75 -> kb_out=131 (Up), then 0. Plain 0x75 (keypad 8) -> kb_out stays 0.
- 0x1C with the parity bit flipped -> frame_err pulses once, code_valid stays 0, kb_out unchanged.
- Make 0x5A (Enter, kb_out=128), make 0x29 (kb_out=32), break 5A -> kb_out stays 32; break 29 -> kb_out=0.
- Send 5 bits of a frame, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses and FSM returns to IDLE; a following full frame 0x76 gives kb_out=140.
- Assert reset=0 mid-frame while kb_out=65 -> kb_out=0 immediately (asynchronously); after release, a fresh 0x66 frame gives kb_out=129 with no residual bits.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared Hack keyboard definitions: key-code constants, PS/2 prefix bytes
// and the frame receiver state encoding.
package hack_pkg;

  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_HOME      = 16'd134;
  localparam logic [15:0] KEY_END       = 16'd135;
  localparam logic [15:0] KEY_PGUP      = 16'd136;
  localparam logic [15:0] KEY_PGDN      = 16'd137;
  localparam logic [15:0] KEY_INSERT    = 16'd138;
  localparam logic [15:0] KEY_DELETE    = 16'd139;
  localparam logic [15:0] KEY_ESC       = 16'd140;
  localparam logic [15:0] KEY_F1        = 16'd141;
  localparam logic [15:0] KEY_F12       = 16'd152;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

endpackage

// File: rtl/ps2_scan_xlate.sv
// Combinational PS/2 set-2 scan code to Hack key-code lookup.
// Extended and plain codes only match their own prefix state.
module ps2_scan_xlate
  import hack_pkg::*;
(
  input  logic        i_ext,
  input  logic [7:0]  i_scan,
  output logic [15:0] o_hack_code
);

  always_comb begin
    o_hack_code = '0;
    case ({i_ext, i_scan})
      9'h01C: o_hack_code = 16'd65;   // A
      9'h032: o_hack_code = 16'd66;
      9'h021: o_hack_code = 16'd67;
      9'h023: o_hack_code = 16'd68;
      9'h024: o_hack_code = 16'd69;
      9'h02B: o_hack_code = 16'd70;
      9'h034: o_hack_code = 16'd71;
      9'h033: o_hack_code = 16'd72;
      9'h043: o_hack_code = 16'd73;
      9'h03B: o_hack_code = 16'd74;
      9'h042: o_hack_code = 16'd75;
      9'h04B: o_hack_code = 16'd76;
      9'h03A: o_hack_code = 16'd77;
      9'h031: o_hack_code = 16'd78;
      9'h044: o_hack_code = 16'd79;
      9'h04D: o_hack_code = 16'd80;
      9'h015: o_hack_code = 16'd81;
      9'h02D: o_hack_code = 16'd82;
      9'h01B: o_hack_code = 16'd83;
      9'h02C: o_hack_code = 16'd84;
      9'h03C: o_hack_code = 16'd85;
      9'h02A: o_hack_code = 16'd86;
      9'h01D: o_hack_code = 16'd87;
      9'h022: o_hack_code = 16'd88;
      9'h035: o_hack_code = 16'd89;
      9'h01A: o_hack_code = 16'd90;   // Z
      9'h045: o_hack_code = 16'd48;   // 0
      9'h016: o_hack_code = 16'd49;
      9'h01E: o_hack_code = 16'd50;
      9'h026: o_hack_code = 16'd51;
      9'h025: o_hack_code = 16'd52;
      9'h02E: o_hack_code = 16'd53;
      9'h036: o_hack_code = 16'd54;
      9'h03D: o_hack_code = 16'd55;
      9'h03E: o_hack_code = 16'd56;
      9'h046: o_hack_code = 16'd57;   // 9
      9'h029: o_hack_code = 16'd32;
      9'h05A: o_hack_code = KEY_NEWLINE;
      9'h066: o_hack_code = KEY_BACKSPACE;
      9'h076: o_hack_code = KEY_ESC;
      9'h005: o_hack_code = KEY_F1;
      9'h006: o_hack_code = 16'd142;
      9'h004: o_hack_code = 16'd143;
      9'h00C: o_hack_code = 16'd144;
      9'h003: o_hack_code = 16'd145;
      9'h00B: o_hack_code = 16'd146;
      9'h083: o_hack_code = 16'd147;
      9'h00A: o_hack_code = 16'd148;
      9'h001: o_hack_code = 16'd149;
      9'h009: o_hack_code = 16'd150;
      9'h078: o_hack_code = 16'd151;
      9'h007: o_hack_code = KEY_F12;
      9'h16B: o_hack_code = KEY_LEFT;
      9'h175: o_hack_code = KEY_UP;
      9'h174: o_hack_code = KEY_RIGHT;
      9'h172: o_hack_code = KEY_DOWN;
      9'h16C: o_hack_code = KEY_HOME;
      9'h169: o_hack_code = KEY_END;
      9'h17D: o_hack_code = KEY_PGUP;
      9'h17A: o_hack_code = KEY_PGDN;
      9'h170: o_hack_code = KEY_INSERT;
      9'h171: o_hack_code = KEY_DELETE;
      default: o_hack_code = '0;
    endcase
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver producing the Hack memory-mapped keyboard word:
// line conditioning, frame FSM with timeout, prefix decoder and translation.
module ps2_keyboard
  import hack_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kb_out,
  output logic        code_valid,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            r_clk_sync;
  logic [1:0]            r_data_sync;
  logic [FILTER_LEN-1:0] r_clk_hist;
  logic                  r_clk_filt;
  logic                  r_fall;
  logic                  r_bit;

  frame_state_t          r_state;
  frame_state_t          w_state_nxt;
  logic [2:0]            r_bitcnt;
  logic [7:0]            r_shift;
  logic                  r_parity;
  logic [TW-1:0]         r_timer;
  logic [7:0]            r_byte;
  logic                  r_code_valid;
  logic                  r_frame_err;

  logic                  r_ext;
  logic                  r_brk;
  logic [15:0]           r_kb;
  logic [15:0]           w_hack;

  logic                  w_fall_det;
  logic                  w_timeout;
  logic                  w_frame_done;
  logic                  w_frame_good;

  // The filtered level only moves once the whole history agrees, so a
  // falling edge is seen exactly once per stable 1->0 transition.
  assign w_fall_det = r_clk_filt & ~(|r_clk_hist);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_hist  <= '1;
      r_clk_filt  <= 1'b1;
      r_fall      <= 1'b0;
      r_bit       <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_clk_hist  <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
      if (&r_clk_hist)
        r_clk_filt <= 1'b1;
      else if (~(|r_clk_hist))
        r_clk_filt <= 1'b0;
      r_fall <= w_fall_det;
      if (w_fall_det)
        r_bit <= r_data_sync[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else if (r_fall) begin
      case (r_state)
        ST_IDLE:   if (!r_bit) w_state_nxt = ST_DATA;
        ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_timeout    = (r_state != ST_IDLE) && !r_fall &&
                   (r_timer == TW'(TIMEOUT_CYCLES - 1));
    w_frame_done = r_fall && (r_state == ST_STOP);
    w_frame_good = w_frame_done && r_bit && (^{r_shift, r_parity});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_timer      <= '0;
      r_byte       <= '0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= w_frame_good;
      r_frame_err  <= (w_frame_done && !w_frame_good) || w_timeout;
      if (r_state == ST_IDLE || r_fall || w_timeout)
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;
      if (r_fall) begin
        case (r_state)
          ST_IDLE:   r_bitcnt <= '0;
          ST_DATA: begin
            r_shift  <= {r_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
          ST_PARITY: r_parity <= r_bit;
          default:   ;
        endcase
      end
      if (w_frame_good)
        r_byte <= r_shift;
    end
  end

  ps2_scan_xlate u_xlate (
    .i_ext       (r_ext),
    .i_scan      (r_byte),
    .o_hack_code (w_hack)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
      r_kb  <= '0;
    end else if (r_code_valid) begin
      if (r_byte == PS2_EXT) begin
        r_ext <= 1'b1;
      end else if (r_byte == PS2_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (w_hack != '0) begin
          if (!r_brk)
            r_kb <= w_hack;
          else if (w_hack == r_kb)
            r_kb <= '0;
        end
      end
    end
  end

  assign kb_out     = r_kb;
  assign code_valid = r_code_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus random
// make/break traffic against a key-table reference model.
module tb_ps2_keyboard;

  localparam int unsigned TMO  = 1000;
  localparam int unsigned HALF = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] kb_out;
  logic        code_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  logic [15:0] kb_before = '0;
  logic [15:0] kb_after = '0;
  bit cap_next = 0;

  typedef struct {
    bit          ext;
    logic [7:0]  scan;
    logic [15:0] code;
  } key_t;
  key_t keys[$];

  ps2_keyboard #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .kb_out     (kb_out),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_next) begin
      kb_after = kb_out;
      cap_next = 0;
    end
    if (code_valid === 1'b1) begin
      n_valid++;
      kb_before = kb_out;
      cap_next = 1;
    end
    if (frame_err === 1'b1) n_err++;
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 0, 0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (kb_out !== 16'd0 || code_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: kb_out=%0d code_valid=%b frame_err=%b required 0/0/0", kb_out, code_valid, frame_err);
    end
    reset = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_make_break_a;
    int v0;
    v0 = n_valid;
    send_byte(8'h1C);
    checks++;
    if (kb_before !== 16'd0 || kb_after !== 16'd65) begin
      errors++;
      $display("FAIL make_a_latency: kb at valid=%0d after=%0d required 0 then 65", kb_before, kb_after);
    end
    send_byte(8'hF0);
    checks++;
    if (kb_out !== 16'd65) begin
      errors++;
      $display("FAIL brk_prefix_hold: kb_out=%0d required 65", kb_out);
    end
    send_byte(8'h1C);
    checks++;
    if (n_valid - v0 !== 3) begin
      errors++;
      $display("FAIL make_break_valid_count: got %0d required 3", n_valid - v0);
    end
    checks++;
    if (kb_out !== 16'd0) begin
      errors++;
      $display("FAIL break_a: kb_out=%0d required 0", kb_out);
    end
  endtask

  task automatic test_extended;
    send_byte(8'hE0);
    send_byte(8'h75);
    checks++;
    if (kb_out !== 16'd131) begin
      errors++;
      $display("FAIL ext_up_make: kb_out=%0d required 131", kb_out);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    checks++;
    if (kb_out !== 16'd0) begin
      errors++;
      $display("FAIL ext_up_break: kb_out=%0d required 0", kb_out);
    end
    send_byte(8'h75);
    checks++;
    if (kb_out !== 16'd0) begin
      errors++;
      $display("FAIL plain_keypad8: kb_out=%0d required 0", kb_out);
    end
  endtask

  task automatic test_frame_errors;
    int v0, e0;
    send_byte(8'h1C);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h1C, 1, 0);
    checks++;
    if (n_err - e0 !== 1 || n_valid !== v0 || kb_out !== 16'd65) begin
      errors++;
      $display("FAIL parity_err: errs=%0d valids=%0d kb_out=%0d required 1/0/65", n_err - e0, n_valid - v0, kb_out);
    end
    send_frame(8'h29, 0, 1);
    checks++;
    if (n_err - e0 !== 2 || n_valid !== v0 || kb_out !== 16'd65) begin
      errors++;
      $display("FAIL stop_err: errs=%0d valids=%0d kb_out=%0d required 2/0/65", n_err - e0, n_valid - v0, kb_out);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++;
    if (kb_out !== 16'd0) begin
      errors++;
      $display("FAIL err_recover: kb_out=%0d required 0", kb_out);
    end
  endtask

  task automatic test_last_make_wins;
    send_byte(8'h5A);
    checks++;
    if (kb_out !== 16'd128) begin
      errors++;
      $display("FAIL enter_make: kb_out=%0d required 128", kb_out);
    end
    send_byte(8'h29);
    checks++;
    if (kb_out !== 16'd32) begin
      errors++;
      $display("FAIL space_make: kb_out=%0d required 32", kb_out);
    end
    send_byte(8'hF0);
    send_byte(8'h5A);
    checks++;
    if (kb_out !== 16'd32) begin
      errors++;
      $display("FAIL stale_break: kb_out=%0d required 32", kb_out);
    end
    send_byte(8'hF0);
    send_byte(8'h29);
    checks++;
    if (kb_out !== 16'd0) begin
      errors++;
      $display("FAIL space_break: kb_out=%0d required 0", kb_out);
    end
  endtask

  task automatic test_timeout;
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TMO + 100) @(posedge clk);
    checks++;
    if (n_err - e0 !== 1 || n_valid !== v0) begin
      errors++;
      $display("FAIL timeout: errs=%0d valids=%0d required 1/0", n_err - e0, n_valid - v0);
    end
    send_byte(8'h76);
    checks++;
    if (kb_out !== 16'd140) begin
      errors++;
      $display("FAIL after_timeout_esc: kb_out=%0d required 140", kb_out);
    end
    send_byte(8'hF0);
    send_byte(8'h76);
  endtask

  task automatic test_async_reset;
    int e0;
    send_byte(8'h1C);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (kb_out !== 16'd0 || code_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: kb_out=%0d cv=%b fe=%b required 0/0/0", kb_out, code_valid, frame_err);
    end
    repeat (4) @(posedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    e0 = n_err;
    send_byte(8'h66);
    checks++;
    if (kb_out !== 16'd129 || n_err !== e0) begin
      errors++;
      $display("FAIL post_reset_bksp: kb_out=%0d errs=%0d required 129/0", kb_out, n_err - e0);
    end
    send_byte(8'hF0);
    send_byte(8'h66);
  endtask

  task automatic test_random;
    logic [15:0] model;
    logic [7:0]  unmapped [3];
    unmapped[0] = 8'h12;
    unmapped[1] = 8'h6B;
    unmapped[2] = 8'h59;
    model = kb_out === 16'd0 ? 16'd0 : 16'hFFFF;
    for (int n = 0; n < 40; n++) begin
      int unsigned k;
      bit brk;
      brk = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 2);
        if (brk) send_byte(8'hF0);
        send_byte(unmapped[k]);
      end else begin
        k = $urandom_range(0, keys.size() - 1);
        if (keys[k].ext) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_byte(keys[k].scan);
        if (!brk) model = keys[k].code;
        else if (model == keys[k].code) model = 16'd0;
      end
      checks++;
      if (kb_out !== model) begin
        errors++;
        $display("FAIL random_%0d: kb_out=%0d required %0d", n, kb_out, model);
      end
    end
  endtask

  initial begin
    keys.push_back('{0, 8'h1C, 16'd65});
    keys.push_back('{0, 8'h1A, 16'd90});
    keys.push_back('{0, 8'h43, 16'd73});
    keys.push_back('{0, 8'h45, 16'd48});
    keys.push_back('{0, 8'h46, 16'd57});
    keys.push_back('{0, 8'h29, 16'd32});
    keys.push_back('{0, 8'h5A, 16'd128});
    keys.push_back('{0, 8'h66, 16'd129});
    keys.push_back('{0, 8'h76, 16'd140});
    keys.push_back('{0, 8'h05, 16'd141});
    keys.push_back('{0, 8'h83, 16'd147});
    keys.push_back('{0, 8'h07, 16'd152});
    keys.push_back('{1, 8'h6B, 16'd130});
    keys.push_back('{1, 8'h74, 16'd132});
    keys.push_back('{1, 8'h72, 16'd133});
    keys.push_back('{1, 8'h6C, 16'd134});
    keys.push_back('{1, 8'h7D, 16'd136});
    keys.push_back('{1, 8'h71, 16'd139});

    test_reset();
    test_make_break_a();
    test_extended();
    test_frame_errors();
    test_last_make_wins();
    test_timeout();
    test_async_reset();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
